// File: rtl/alu_shift_mem_unit_pkg.sv
// Shared constants for the execute stage: datapath widths, ALU opcodes and
// result mux encodings.
package alu_shift_mem_unit_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MEM_DEPTH = 256;
    localparam int unsigned ADDR_W    = $clog2(MEM_DEPTH);

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_NOTA  = 3'b101;
    localparam logic [2:0] ALU_PASSA = 3'b110;
    localparam logic [2:0] ALU_PASSB = 3'b111;

    localparam logic [1:0] RES_ALU   = 2'b00;
    localparam logic [1:0] RES_SHIFT = 2'b01;
    localparam logic [1:0] RES_MEM   = 2'b10;
    localparam logic [1:0] RES_ZERO  = 2'b11;

endpackage

// File: rtl/alu_shift_mem_barrel_shifter.sv
// Combinational 8-bit barrel shifter: logical shift or rotate, left or right,
// with the last bit moved out reported as carry.
module alu_shift_mem_barrel_shifter
    import alu_shift_mem_unit_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    input  logic [2:0]        count_i,
    input  logic              dir_i,
    input  logic              ro_bar_i,
    output logic [DATA_W-1:0] shift_o,
    output logic              carry_o,
    output logic              zero_o
);

    logic [DATA_W-1:0] shl;
    logic [DATA_W-1:0] shr;
    logic [DATA_W-1:0] rol;
    logic [DATA_W-1:0] ror;
    logic [3:0]        back_cnt;
    logic [2:0]        idx_l;
    logic [2:0]        idx_r;

    // For count 0 the complementary shift is by 8, which yields zero.
    assign back_cnt = 4'd8 - {1'b0, count_i};
    assign shl      = data_i << count_i;
    assign shr      = data_i >> count_i;
    assign rol      = shl | (data_i >> back_cnt);
    assign ror      = shr | (data_i << back_cnt);

    // 8-n taken modulo 8 is the same bit as -n for n in 1..7.
    assign idx_l = 3'd0 - count_i;
    assign idx_r = count_i - 3'd1;

    always_comb begin
        shift_o = data_i;
        carry_o = 1'b0;
        if (count_i != 3'd0) begin
            if (!dir_i) begin
                shift_o = ro_bar_i ? shl : rol;
                carry_o = data_i[idx_l];
            end else begin
                shift_o = ro_bar_i ? shr : ror;
                carry_o = data_i[idx_r];
            end
        end
    end

    assign zero_o = (shift_o == '0);

endmodule

// File: rtl/alu_shift_mem_unit.sv
// Execute stage: ALU, barrel shifter, 256x8 data memory addressed by the ALU
// result, carry/zero flag registers and the result mux.
module alu_shift_mem_unit
    import alu_shift_mem_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_a,
    input  logic [DATA_W-1:0] alu_b,
    input  logic              alu_use_carry,
    input  logic [2:0]        sh_count,
    input  logic              sh_dir,
    input  logic              sh_ro_bar,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [1:0]        result_sel,
    input  logic              select_c,
    input  logic              select_z,
    input  logic              write_c,
    input  logic              write_z,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] shift_out,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] result,
    output logic              C,
    output logic              Z
);

    logic              c_q, c_d;
    logic              z_q, z_d;
    logic              cin;
    logic [DATA_W:0]   sum;
    logic              alu_co;
    logic              alu_z;
    logic              shift_c;
    logic              shift_z;
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    assign cin = alu_use_carry & c_q;

    always_comb begin
        sum     = '0;
        alu_out = '0;
        alu_co  = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                sum     = {1'b0, alu_a} + {1'b0, alu_b} + {{DATA_W{1'b0}}, cin};
                alu_out = sum[DATA_W-1:0];
                alu_co  = sum[DATA_W];
            end
            ALU_SUB: begin
                // Bit 8 of the 9-bit difference is the borrow.
                sum     = {1'b0, alu_a} - {1'b0, alu_b} - {{DATA_W{1'b0}}, cin};
                alu_out = sum[DATA_W-1:0];
                alu_co  = sum[DATA_W];
            end
            ALU_AND:   alu_out = alu_a & alu_b;
            ALU_OR:    alu_out = alu_a | alu_b;
            ALU_XOR:   alu_out = alu_a ^ alu_b;
            ALU_NOTA:  alu_out = ~alu_a;
            ALU_PASSA: alu_out = alu_a;
            default:   alu_out = alu_b;
        endcase
    end

    assign alu_z = (alu_out == '0);

    alu_shift_mem_barrel_shifter u_shifter (
        .data_i   (alu_a),
        .count_i  (sh_count),
        .dir_i    (sh_dir),
        .ro_bar_i (sh_ro_bar),
        .shift_o  (shift_out),
        .carry_o  (shift_c),
        .zero_o   (shift_z)
    );

    // Contents are deliberately left uninitialised and survive reset.
    always_ff @(posedge clk) begin
        if (reset && mem_write) begin
            mem_q[alu_out] <= mem_wdata;
        end
    end

    assign mem_rdata = mem_q[alu_out];

    always_comb begin
        c_d = c_q;
        z_d = z_q;
        if (!reset) begin
            c_d = 1'b0;
            z_d = 1'b0;
        end else begin
            if (write_c) c_d = select_c ? shift_c : alu_co;
            if (write_z) z_d = select_z ? shift_z : alu_z;
        end
    end

    always_ff @(posedge clk) begin
        c_q <= c_d;
        z_q <= z_d;
    end

    always_comb begin
        result = '0;
        case (result_sel)
            RES_ALU:   result = alu_out;
            RES_SHIFT: result = shift_out;
            RES_MEM:   result = mem_rdata;
            default:   result = '0;
        endcase
    end

    assign C = c_q;
    assign Z = z_q;

endmodule

// File: tb/tb_alu_shift_mem_unit.sv
// Self-checking bench for alu_shift_mem_unit: directed scenarios plus random
// stimulus against an arithmetic reference model of ALU, shifter, flags and memory.
module tb_alu_shift_mem_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] alu_op;
    logic [7:0] alu_a, alu_b;
    logic       alu_use_carry;
    logic [2:0] sh_count;
    logic       sh_dir, sh_ro_bar;
    logic       mem_write;
    logic [7:0] mem_wdata;
    logic [1:0] result_sel;
    logic       select_c, select_z, write_c, write_z;
    logic [7:0] alu_out, shift_out, mem_rdata, result;
    logic       C, Z;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    int m_c = 0, m_z = 0;
    int mem_m [256];
    bit mem_v [256];
    // Predicted combinational values for the current inputs
    int e_alu, e_co, e_sh, e_sc;

    alu_shift_mem_unit dut (
        .clk           (clk),
        .reset         (reset),
        .alu_op        (alu_op),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_use_carry (alu_use_carry),
        .sh_count      (sh_count),
        .sh_dir        (sh_dir),
        .sh_ro_bar     (sh_ro_bar),
        .mem_write     (mem_write),
        .mem_wdata     (mem_wdata),
        .result_sel    (result_sel),
        .select_c      (select_c),
        .select_z      (select_z),
        .write_c       (write_c),
        .write_z       (write_z),
        .alu_out       (alu_out),
        .shift_out     (shift_out),
        .mem_rdata     (mem_rdata),
        .result        (result),
        .C             (C),
        .Z             (Z)
    );

    always #5 clk = ~clk;

    function automatic void ref_alu(input int op, input int a, input int b, input int cin,
                                    output int r, output int co);
        int s;
        co = 0;
        case (op)
            0: begin s = a + b + cin; r = s % 256; co = (s > 255) ? 1 : 0; end
            1: begin s = a - b - cin; r = (s + 256) % 256; co = (s < 0) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: r = a;
            default: r = b;
        endcase
    endfunction

    // Moves the word one bit at a time, remembering the bit that fell off.
    function automatic void ref_shift(input int a, input int n, input int right, input int rot,
                                      output int r, output int c);
        r = a;
        c = 0;
        for (int i = 0; i < n; i++) begin
            if (right == 0) begin
                c = (r >> 7) & 1;
                r = ((r << 1) & 255) | (rot != 0 ? c : 0);
            end else begin
                c = r & 1;
                r = (r >> 1) | (rot != 0 ? (c << 7) : 0);
            end
        end
    endfunction

    task automatic predict();
        ref_alu(int'(alu_op), int'(alu_a), int'(alu_b), alu_use_carry ? m_c : 0, e_alu, e_co);
        ref_shift(int'(alu_a), int'(sh_count), int'(sh_dir), sh_ro_bar ? 0 : 1, e_sh, e_sc);
    endtask

    task automatic tick();
        predict();
        @(posedge clk);
        if (!reset) begin
            m_c = 0;
            m_z = 0;
        end else begin
            if (write_c) m_c = select_c ? e_sc : e_co;
            if (write_z) m_z = select_z ? ((e_sh == 0) ? 1 : 0) : ((e_alu == 0) ? 1 : 0);
            if (mem_write) begin
                mem_m[e_alu] = int'(mem_wdata);
                mem_v[e_alu] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle();
        reset = 1'b1; alu_op = 3'b000; alu_a = 8'h00; alu_b = 8'h00; alu_use_carry = 1'b0;
        sh_count = 3'd0; sh_dir = 1'b0; sh_ro_bar = 1'b1; mem_write = 1'b0;
        mem_wdata = 8'h00; result_sel = 2'b00; select_c = 1'b0; select_z = 1'b0;
        write_c = 1'b0; write_z = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0; write_c = 1'b1; write_z = 1'b1;
        alu_op = 3'b000; alu_a = 8'hFF; alu_b = 8'h01;  // would give C=1, Z=1
        tick();
        n_checks++; if (C !== 1'b0) begin n_errors++; $display("FAIL reset_c: got %b want 0", C); end
        n_checks++; if (Z !== 1'b0) begin n_errors++; $display("FAIL reset_z: got %b want 0", Z); end
    endtask

    task automatic test_add();
        idle();
        write_c = 1'b1; write_z = 1'b1; alu_op = 3'b000; alu_a = 8'hF0; alu_b = 8'h20;
        #1;
        n_checks++; if (alu_out !== 8'h10) begin n_errors++; $display("FAIL add_out: got %h want 10", alu_out); end
        n_checks++; if (result !== 8'h10) begin n_errors++; $display("FAIL add_result: got %h want 10", result); end
        tick();
        n_checks++; if (C !== 1'b1) begin n_errors++; $display("FAIL add_c: got %b want 1", C); end
        n_checks++; if (Z !== 1'b0) begin n_errors++; $display("FAIL add_z: got %b want 0", Z); end
        alu_a = 8'h01; alu_b = 8'h00; alu_use_carry = 1'b1;
        #1;
        n_checks++; if (alu_out !== 8'h02) begin n_errors++; $display("FAIL adc_out: got %h want 02", alu_out); end
        tick();
        n_checks++; if (C !== 1'b0) begin n_errors++; $display("FAIL adc_c: got %b want 0", C); end
    endtask

    task automatic test_sub();
        idle();
        write_c = 1'b1; write_z = 1'b1; alu_op = 3'b001; alu_a = 8'h05; alu_b = 8'h05;
        #1;
        n_checks++; if (alu_out !== 8'h00) begin n_errors++; $display("FAIL sub_eq_out: got %h want 00", alu_out); end
        tick();
        n_checks++; if (Z !== 1'b1) begin n_errors++; $display("FAIL sub_eq_z: got %b want 1", Z); end
        n_checks++; if (C !== 1'b0) begin n_errors++; $display("FAIL sub_eq_c: got %b want 0", C); end
        alu_a = 8'h03; alu_b = 8'h04;
        #1;
        n_checks++; if (alu_out !== 8'hFF) begin n_errors++; $display("FAIL sub_lt_out: got %h want ff", alu_out); end
        tick();
        n_checks++; if (C !== 1'b1) begin n_errors++; $display("FAIL sub_lt_c: got %b want 1", C); end
        n_checks++; if (Z !== 1'b0) begin n_errors++; $display("FAIL sub_lt_z: got %b want 0", Z); end
    endtask

    task automatic test_shifter();
        logic [7:0] want_out [4];
        logic       want_c [4];
        logic [2:0] cnt [4];
        logic       dir [4];
        logic       ro_bar [4];
        // shl 1, shr 7, ror 1, count 0
        want_out = '{8'h02, 8'h01, 8'hC0, 8'h81};
        want_c   = '{1'b1, 1'b0, 1'b1, 1'b0};
        cnt      = '{3'd1, 3'd7, 3'd1, 3'd0};
        dir      = '{1'b0, 1'b1, 1'b1, 1'b0};
        ro_bar   = '{1'b1, 1'b1, 1'b0, 1'b0};
        idle();
        alu_a = 8'h81; select_c = 1'b1; write_c = 1'b1; result_sel = 2'b01;
        for (int i = 0; i < 4; i++) begin
            sh_count = cnt[i]; sh_dir = dir[i]; sh_ro_bar = ro_bar[i];
            #1;
            n_checks++;
            if (result !== want_out[i]) begin
                n_errors++; $display("FAIL shift_out[%0d]: got %h want %h", i, result, want_out[i]);
            end
            tick();
            n_checks++;
            if (C !== want_c[i]) begin
                n_errors++; $display("FAIL shift_c[%0d]: got %b want %b", i, C, want_c[i]);
            end
        end
    endtask

    task automatic test_memory();
        idle();
        alu_op = 3'b111; alu_b = 8'h3C; mem_write = 1'b1; mem_wdata = 8'hA5;
        #1;
        n_checks++; if (alu_out !== 8'h3C) begin n_errors++; $display("FAIL mem_addr: got %h want 3c", alu_out); end
        tick();
        mem_write = 1'b0; result_sel = 2'b10;
        #1;
        n_checks++; if (result !== 8'hA5) begin n_errors++; $display("FAIL mem_read: got %h want a5", result); end
        // Raise both flags, then reset with every enable active.
        alu_b = 8'h00; alu_a = 8'h81; sh_count = 3'd1; select_c = 1'b1; write_c = 1'b1;
        write_z = 1'b1;
        tick();
        n_checks++; if (C !== 1'b1 || Z !== 1'b1) begin n_errors++; $display("FAIL flags_set: got C=%b Z=%b want 1 1", C, Z); end
        reset = 1'b0; alu_b = 8'h3C; mem_write = 1'b1; mem_wdata = 8'hFF;
        tick();
        n_checks++; if (C !== 1'b0 || Z !== 1'b0) begin n_errors++; $display("FAIL reset_flags: got C=%b Z=%b want 0 0", C, Z); end
        reset = 1'b1; mem_write = 1'b0;
        #1;
        n_checks++; if (mem_rdata !== 8'hA5) begin n_errors++; $display("FAIL reset_mem: got %h want a5", mem_rdata); end
        // Read during write: old data before the edge, new after.
        mem_write = 1'b1; mem_wdata = 8'h5A;
        #1;
        n_checks++; if (mem_rdata !== 8'hA5) begin n_errors++; $display("FAIL rdw_old: got %h want a5", mem_rdata); end
        tick();
        mem_write = 1'b0;
        #1;
        n_checks++; if (mem_rdata !== 8'h5A) begin n_errors++; $display("FAIL rdw_new: got %h want 5a", mem_rdata); end
    endtask

    task automatic test_hold();
        idle();
        alu_op = 3'b000; alu_a = 8'h01; alu_b = 8'h01; write_c = 1'b1; write_z = 1'b1;
        tick();
        write_c = 1'b0; write_z = 1'b0; alu_a = 8'hFF; alu_b = 8'h01;  // co=1, zero=1
        tick();
        n_checks++; if (C !== 1'b0) begin n_errors++; $display("FAIL hold_c: got %b want 0", C); end
        n_checks++; if (Z !== 1'b0) begin n_errors++; $display("FAIL hold_z: got %b want 0", Z); end
        alu_a = 8'hF0; alu_b = 8'h20; result_sel = 2'b11;
        #1;
        n_checks++; if (result !== 8'h00) begin n_errors++; $display("FAIL const_zero: got %h want 00", result); end
    endtask

    task automatic test_random();
        int want_res;
        bit known;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 15) != 0);
            alu_op = 3'($urandom); alu_a = 8'($urandom); alu_b = 8'($urandom);
            alu_use_carry = 1'($urandom); sh_count = 3'($urandom); sh_dir = 1'($urandom);
            sh_ro_bar = 1'($urandom); mem_write = 1'($urandom); mem_wdata = 8'($urandom);
            result_sel = 2'($urandom); select_c = 1'($urandom); select_z = 1'($urandom);
            write_c = 1'($urandom); write_z = 1'($urandom);
            if (i % 3 == 0) alu_b = 8'($urandom_range(0, 7));  // revisit a few addresses
            #1;
            predict();
            n_checks++;
            if (alu_out !== 8'(e_alu)) begin
                n_errors++; $display("FAIL rnd_alu[%0d]: got %h want %h", i, alu_out, 8'(e_alu));
            end
            n_checks++;
            if (shift_out !== 8'(e_sh)) begin
                n_errors++; $display("FAIL rnd_shift[%0d]: got %h want %h", i, shift_out, 8'(e_sh));
            end
            known = 1'b1;
            case (result_sel)
                2'b00: want_res = e_alu;
                2'b01: want_res = e_sh;
                2'b10: begin want_res = mem_m[e_alu]; known = mem_v[e_alu]; end
                default: want_res = 0;
            endcase
            if (known) begin
                n_checks++;
                if (result !== 8'(want_res)) begin
                    n_errors++; $display("FAIL rnd_result[%0d]: got %h want %h", i, result, 8'(want_res));
                end
            end
            tick();
            n_checks++;
            if (C !== 1'(m_c) || Z !== 1'(m_z)) begin
                n_errors++; $display("FAIL rnd_flags[%0d]: got C=%b Z=%b want %0d %0d", i, C, Z, m_c, m_z);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_m[i] = 0;
            mem_v[i] = 1'b0;
        end
        idle();
        reset = 1'b0;
        tick();
        test_reset();
        test_add();
        test_sub();
        test_shifter();
        test_memory();
        test_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
